instr_fetch_unit: RTL and testbench

//  Initiator side of the instruction_mem read port: owns the PC, drives imem_addr, captures returned

---
 rtl/mips32_pkg.sv | 30 +++
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit_buffer.sv | 59 +++++
 rtl/instr_fetch_unit.sv | 91 +++++++++
 tb/tb_instr_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_pkg.sv
// Shared definitions for the instruction fetch slice.
//  WORD_W              : datapath / address width
//  IMEM_WORDS_DEFAULT  : default instruction_mem depth in words
//  NOP                 : NOP instruction encoding
//  fetch_state_t       : fetch FSM state encoding
//  fetch_entry_t       : one fetch buffer entry {pc, instr}
//  wrap_pc()           : reduce a word address modulo a power-of-2 memory depth
package mips32_pkg;

  localparam int unsigned WORD_W             = 32;
  localparam int unsigned IMEM_WORDS_DEFAULT = 128;
  localparam logic [WORD_W-1:0] NOP          = '0;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] wrap_pc(input logic [WORD_W-1:0] pc,
                                                input int unsigned       words);
    return pc & WORD_W'(words - 1);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction_mem and decode.
//  imem_addr/imem_rdata          : instruction_mem read port (combinational read)
//  dec_valid/dec_ready           : handshake towards decode
//  dec_instr/dec_pc              : head entry payload
//  redirect_valid/redirect_pc    : branch/jump PC reload
//  master : fetch unit side      slave : memory/decode/branch side
interface instr_fetch_unit_if;
  import mips32_pkg::*;

  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_rdata;
  logic              dec_valid;
  logic              dec_ready;
  logic [WORD_W-1:0] dec_instr;
  logic [WORD_W-1:0] dec_pc;
  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_pc;

  modport master (
    output imem_addr, dec_valid, dec_instr, dec_pc,
    input  imem_rdata, dec_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, dec_valid, dec_instr, dec_pc,
    output imem_rdata, dec_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_unit_buffer.sv
// fetch_buffer: small {pc, instr} FIFO sitting between fetch and decode.
//  clk, rst_n : clock, asynchronous active-low reset (clears all entries)
//  push       : write wr_entry at the tail
//  pop        : retire the head entry
//  flush      : discard all entries (takes priority over push/pop)
//  wr_entry   : entry to write
//  count      : number of valid entries
//  full       : count == BUF_DEPTH
//  head       : entry at the head (meaningless when count == 0)
module fetch_buffer
  import mips32_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic [1:0]   count,
  output logic         full,
  output fetch_entry_t head
);

  fetch_entry_t entries [BUF_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;

  assign head = entries[rd_ptr];
  assign full = (count == 2'(BUF_DEPTH));

  // Push into a full buffer is only issued together with a pop; the slot
  // written is the one being retired in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        entries[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= wr_entry;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, reads instruction_mem and hands {pc, instr}
// pairs to decode through a 2-entry fetch buffer. A redirect flushes the
// buffer and reloads the PC.
//  clk   : rising-edge clock
//  rst_n : asynchronous active-low reset
//  bus   : instr_fetch_unit_if.master (imem_*, dec_*, redirect_*)
module instr_fetch_unit
  import mips32_pkg::*;
#(
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  localparam logic [WORD_W-1:0] RESET_PC_W = wrap_pc(WORD_W'(RESET_PC), IMEM_WORDS);

  fetch_state_t      state;
  logic [WORD_W-1:0] fetch_pc;
  logic [WORD_W-1:0] redirect_target;
  logic [WORD_W-1:0] next_pc;
  logic [1:0]        count;
  logic              full;
  logic              push;
  logic              pop;
  fetch_entry_t      head;
  fetch_entry_t      wr_entry;

  assign redirect_target = wrap_pc(bus.redirect_pc, IMEM_WORDS);
  assign next_pc         = wrap_pc(fetch_pc + 32'd1, IMEM_WORDS);

  assign bus.imem_addr = fetch_pc;
  assign bus.dec_valid = (count != '0);
  assign bus.dec_instr = head.instr;
  assign bus.dec_pc    = head.pc;

  assign pop  = bus.dec_valid & bus.dec_ready;
  assign push = (state == S_RUN) & ~bus.redirect_valid & (~full | pop);

  assign wr_entry = '{pc: fetch_pc, instr: bus.imem_rdata};

  fetch_buffer #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (bus.redirect_valid),
    .wr_entry (wr_entry),
    .count    (count),
    .full     (full),
    .head     (head)
  );

  // BOOT and FLUSH are one-cycle address settle states: fetch_pc is loaded
  // but nothing is pushed until RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      fetch_pc <= RESET_PC_W;
    end else begin
      unique case (state)
        S_BOOT: begin
          state <= S_RUN;
          if (bus.redirect_valid) fetch_pc <= redirect_target;
        end
        S_RUN: begin
          if (bus.redirect_valid) begin
            state    <= S_FLUSH;
            fetch_pc <= redirect_target;
          end else if (push) begin
            fetch_pc <= next_pc;
          end
        end
        S_FLUSH: begin
          if (bus.redirect_valid) fetch_pc <= redirect_target;
          else                    state    <= S_RUN;
        end
        default: begin
          state    <= S_BOOT;
          fetch_pc <= RESET_PC_W;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import mips32_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst2_n;

  int tests_run    = 0;
  int tests_failed = 0;
  int unsigned exp_pc;

  logic [31:0] mem [128];
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'(i + 100);
  end

  instr_fetch_unit_if bus1 ();
  instr_fetch_unit_if bus2 ();

  assign bus1.imem_rdata = mem[bus1.imem_addr[6:0]];
  assign bus2.imem_rdata = mem[bus2.imem_addr[6:0]];

  instr_fetch_unit #(
    .RESET_PC   (0),
    .IMEM_WORDS (128),
    .BUF_DEPTH  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  instr_fetch_unit #(
    .RESET_PC   (126),
    .IMEM_WORDS (128),
    .BUF_DEPTH  (2)
  ) dut_wrap (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    bus1.dec_ready      = 1'b1;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_pc    = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus1.dec_valid !== 1'b0 || bus1.imem_addr !== 32'd0 ||
        bus1.dec_pc !== 32'd0 || bus1.dec_instr !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_values: valid=%b addr=%0d pc=%0d instr=%0d, expected 0 0 0 0",
               bus1.dec_valid, bus1.imem_addr, bus1.dec_pc, bus1.dec_instr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus1.dec_valid !== 1'b0 || bus1.imem_addr !== 32'd0) begin
      tests_failed++;
      $display("FAIL boot_settle: valid=%b addr=%0d, expected 0 0",
               bus1.dec_valid, bus1.imem_addr);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus1.dec_valid !== 1'b1 || bus1.dec_pc !== 32'(k) ||
          bus1.dec_instr !== 32'(k + 100)) begin
        tests_failed++;
        $display("FAIL stream_%0d: valid=%b pc=%0d instr=%0d, expected 1 %0d %0d",
                 k, bus1.dec_valid, bus1.dec_pc, bus1.dec_instr, k, k + 100);
      end
    end
    exp_pc = 5;
  endtask

  task automatic test_stall();
    int unsigned p;
    p = exp_pc;
    bus1.dec_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      tests_run++;
      if (bus1.dec_valid !== 1'b1 || bus1.dec_pc !== 32'(p) ||
          bus1.dec_instr !== 32'(p + 100) || bus1.imem_addr !== 32'(p + 2)) begin
        tests_failed++;
        $display("FAIL stall_%0d: valid=%b pc=%0d instr=%0d addr=%0d, expected 1 %0d %0d %0d",
                 s, bus1.dec_valid, bus1.dec_pc, bus1.dec_instr, bus1.imem_addr,
                 p, p + 100, p + 2);
      end
    end
    bus1.dec_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus1.dec_valid !== 1'b1 || bus1.dec_pc !== 32'(p + k) ||
          bus1.dec_instr !== 32'(p + k + 100)) begin
        tests_failed++;
        $display("FAIL release_%0d: valid=%b pc=%0d instr=%0d, expected 1 %0d %0d",
                 k, bus1.dec_valid, bus1.dec_pc, bus1.dec_instr, p + k, p + k + 100);
      end
    end
    exp_pc = p + 4;
  endtask

  task automatic test_redirect();
    bus1.dec_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus1.dec_valid !== 1'b1 || bus1.dec_pc !== 32'(exp_pc)) begin
      tests_failed++;
      $display("FAIL redirect_pre_full: valid=%b pc=%0d, expected 1 %0d",
               bus1.dec_valid, bus1.dec_pc, exp_pc);
    end
    bus1.redirect_valid = 1'b1;
    bus1.redirect_pc    = 32'd40;
    @(negedge clk);
    bus1.redirect_valid = 1'b0;
    tests_run++;
    if (bus1.dec_valid !== 1'b0 || bus1.imem_addr !== 32'd40) begin
      tests_failed++;
      $display("FAIL redirect_flush: valid=%b addr=%0d, expected 0 40",
               bus1.dec_valid, bus1.imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (bus1.dec_valid !== 1'b0 || bus1.imem_addr !== 32'd40) begin
      tests_failed++;
      $display("FAIL redirect_first_push: valid=%b addr=%0d, expected 0 40",
               bus1.dec_valid, bus1.imem_addr);
    end
    bus1.dec_ready = 1'b1;
    for (int k = 40; k <= 41; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus1.dec_valid !== 1'b1 || bus1.dec_pc !== 32'(k) ||
          bus1.dec_instr !== 32'(k + 100)) begin
        tests_failed++;
        $display("FAIL redirect_stream_%0d: valid=%b pc=%0d instr=%0d, expected 1 %0d %0d",
                 k, bus1.dec_valid, bus1.dec_pc, bus1.dec_instr, k, k + 100);
      end
    end
  endtask

  task automatic test_back_to_back();
    bus1.redirect_valid = 1'b1;
    bus1.redirect_pc    = 32'd10;
    @(negedge clk);
    bus1.redirect_pc = 32'd20;
    tests_run++;
    if (bus1.dec_valid !== 1'b0 || bus1.imem_addr !== 32'd10) begin
      tests_failed++;
      $display("FAIL b2b_first: valid=%b addr=%0d, expected 0 10",
               bus1.dec_valid, bus1.imem_addr);
    end
    @(negedge clk);
    bus1.redirect_valid = 1'b0;
    tests_run++;
    if (bus1.dec_valid !== 1'b0 || bus1.imem_addr !== 32'd20) begin
      tests_failed++;
      $display("FAIL b2b_second: valid=%b addr=%0d, expected 0 20",
               bus1.dec_valid, bus1.imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (bus1.dec_valid !== 1'b0 || bus1.imem_addr !== 32'd20) begin
      tests_failed++;
      $display("FAIL b2b_settle: valid=%b addr=%0d, expected 0 20",
               bus1.dec_valid, bus1.imem_addr);
    end
    for (int k = 20; k <= 21; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus1.dec_valid !== 1'b1 || bus1.dec_pc !== 32'(k) ||
          bus1.dec_instr !== 32'(k + 100)) begin
        tests_failed++;
        $display("FAIL b2b_stream_%0d: valid=%b pc=%0d instr=%0d, expected 1 %0d %0d",
                 k, bus1.dec_valid, bus1.dec_pc, bus1.dec_instr, k, k + 100);
      end
    end
    // 200 mod 128 = 72
    bus1.redirect_valid = 1'b1;
    bus1.redirect_pc    = 32'd200;
    @(negedge clk);
    bus1.redirect_valid = 1'b0;
    tests_run++;
    if (bus1.dec_valid !== 1'b0 || bus1.imem_addr !== 32'd72) begin
      tests_failed++;
      $display("FAIL mask_addr: valid=%b addr=%0d, expected 0 72",
               bus1.dec_valid, bus1.imem_addr);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus1.dec_valid !== 1'b1 || bus1.dec_pc !== 32'd72 || bus1.dec_instr !== 32'd172) begin
      tests_failed++;
      $display("FAIL mask_stream: valid=%b pc=%0d instr=%0d, expected 1 72 172",
               bus1.dec_valid, bus1.dec_pc, bus1.dec_instr);
    end
  endtask

  task automatic test_wrap();
    int unsigned pcs [4];
    pcs = '{126, 127, 0, 1};
    rst2_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus2.dec_valid !== 1'b0 || bus2.imem_addr !== 32'd126) begin
      tests_failed++;
      $display("FAIL wrap_boot: valid=%b addr=%0d, expected 0 126",
               bus2.dec_valid, bus2.imem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus2.dec_valid !== 1'b1 || bus2.dec_pc !== 32'(pcs[k]) ||
          bus2.dec_instr !== 32'(pcs[k] + 100)) begin
        tests_failed++;
        $display("FAIL wrap_%0d: valid=%b pc=%0d instr=%0d, expected 1 %0d %0d",
                 k, bus2.dec_valid, bus2.dec_pc, bus2.dec_instr, pcs[k], pcs[k] + 100);
      end
    end
  endtask

  task automatic test_async_reset();
    bus1.dec_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus1.dec_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_pre: valid=%b, expected 1", bus1.dec_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus1.dec_valid !== 1'b0 || bus1.imem_addr !== 32'd0 ||
        bus1.dec_pc !== 32'd0 || bus1.dec_instr !== 32'd0) begin
      tests_failed++;
      $display("FAIL async_reset: valid=%b addr=%0d pc=%0d instr=%0d, expected 0 0 0 0",
               bus1.dec_valid, bus1.imem_addr, bus1.dec_pc, bus1.dec_instr);
    end
  endtask

  initial begin
    rst2_n              = 1'b0;
    bus2.dec_ready      = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;
    test_reset();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
